wb_regwriter: RTL and testbench

- Writeback-side driver for the 2-write-port, byte-enabled general register file (AX..DI, indices 0-7).
- Accepts EX-stage results, up to two register writes per instruction, through a valid/ready queue.
- Accepts memory load returns, which are never backpressured.
- Schedules both onto the register file's two write ports (we1/waddr1/wdata1, we2/waddr2/wdata2) and exports a per-register pending mask for ID hazard checks.

---
 rtl/wb_regwriter.sv | 232 +++++++++++++++++++++++
 tb/tb_wb_regwriter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regwriter.sv
// wb_regwriter: writeback-side scheduler for the 2-write-port, byte-enabled
// register file (AX..DI). EX results (up to two register writes each) are
// queued through a valid/ready FIFO. Memory load returns are never stalled
// and always use port 2. Each cycle the head entry is issued onto whatever
// port credits remain, splitting a two-slot entry across two cycles if needed.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   - an entry accepted while the queue is empty, whose active slots
//               fit the credits left after a load return, is scheduled in the
//               same cycle and never stored.
//   undefined - every entry passes through the queue.
module wb_regwriter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic [1:0]               ex_we1,
    input  logic [2:0]               ex_waddr1,
    input  logic [15:0]              ex_wdata1,
    input  logic [1:0]               ex_we2,
    input  logic [2:0]               ex_waddr2,
    input  logic [15:0]              ex_wdata2,
    input  logic                     mem_valid,
    input  logic [1:0]               mem_we,
    input  logic [2:0]               mem_waddr,
    input  logic [15:0]              mem_wdata,
    output logic [1:0]               we1,
    output logic [2:0]               waddr1,
    output logic [15:0]              wdata1,
    output logic [1:0]               we2,
    output logic [2:0]               waddr2,
    output logic [15:0]              wdata2,
    output logic [7:0]               pending,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [1:0]  we1;
        logic [2:0]  waddr1;
        logic [15:0] wdata1;
        logic [1:0]  we2;
        logic [2:0]  waddr2;
        logic [15:0] wdata2;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          head_half;

    entry_t        head;
    entry_t        in_entry;
    logic          push;
    logic          store;
    logic          pop;
    logic          half_set;
    logic          bypass;
    logic          head_act1;
    logic          head_act2;

    logic [1:0]    nxt_we1;
    logic [2:0]    nxt_waddr1;
    logic [15:0]   nxt_wdata1;
    logic [1:0]    nxt_we2;
    logic [2:0]    nxt_waddr2;
    logic [15:0]   nxt_wdata2;

    assign in_entry  = {ex_we1, ex_waddr1, ex_wdata1, ex_we2, ex_waddr2, ex_wdata2};
    assign head      = fifo_q[rd_ptr];
    assign ex_ready  = !reset && (count < FULL);
    assign push      = ex_valid && ex_ready;
    assign store     = push && !bypass;

    // Slot 1 of a half-issued head has already gone out; only slot 2 remains.
    assign head_act1 = (|head.we1) && !head_half;
    assign head_act2 = |head.we2;

    // Port schedule for the next cycle: load return on port 2, head entry on
    // the remaining credits, idle ports keep their last address/data.
    always_comb begin
        nxt_we1    = '0;
        nxt_waddr1 = waddr1;
        nxt_wdata1 = wdata1;
        nxt_we2    = '0;
        nxt_waddr2 = waddr2;
        nxt_wdata2 = wdata2;
        pop        = 1'b0;
        half_set   = 1'b0;
        bypass     = 1'b0;

        if (mem_valid) begin
            nxt_we2    = mem_we;
            nxt_waddr2 = mem_waddr;
            nxt_wdata2 = mem_wdata;
        end

        if (count != '0) begin
            unique case ({head_act1, head_act2})
                2'b00: begin
                    pop = 1'b1;
                end
                2'b10: begin
                    nxt_we1    = head.we1;
                    nxt_waddr1 = head.waddr1;
                    nxt_wdata1 = head.wdata1;
                    pop        = 1'b1;
                end
                2'b01: begin
                    nxt_we1    = head.we2;
                    nxt_waddr1 = head.waddr2;
                    nxt_wdata1 = head.wdata2;
                    pop        = 1'b1;
                end
                default: begin
                    nxt_we1    = head.we1;
                    nxt_waddr1 = head.waddr1;
                    nxt_wdata1 = head.wdata1;
                    if (!mem_valid) begin
                        nxt_we2    = head.we2;
                        nxt_waddr2 = head.waddr2;
                        nxt_wdata2 = head.wdata2;
                        pop        = 1'b1;
                    end else begin
                        half_set   = 1'b1;
                    end
                end
            endcase
        end
`ifdef WB_BYPASS_EN
        else if (push) begin
            unique case ({|ex_we1, |ex_we2})
                2'b00: begin
                    bypass = 1'b1;
                end
                2'b10: begin
                    nxt_we1    = ex_we1;
                    nxt_waddr1 = ex_waddr1;
                    nxt_wdata1 = ex_wdata1;
                    bypass     = 1'b1;
                end
                2'b01: begin
                    nxt_we1    = ex_we2;
                    nxt_waddr1 = ex_waddr2;
                    nxt_wdata1 = ex_wdata2;
                    bypass     = 1'b1;
                end
                default: begin
                    if (!mem_valid) begin
                        nxt_we1    = ex_we1;
                        nxt_waddr1 = ex_waddr1;
                        nxt_wdata1 = ex_wdata1;
                        nxt_we2    = ex_we2;
                        nxt_waddr2 = ex_waddr2;
                        nxt_wdata2 = ex_wdata2;
                        bypass     = 1'b1;
                    end
                end
            endcase
        end
`endif
    end

    // Queue storage; contents need no reset because occupancy gates every use.
    always_ff @(posedge clk) begin
        if (store) begin
            fifo_q[wr_ptr] <= in_entry;
        end
    end

    // Queue pointers, occupancy, split-head flag and registered port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_half <= 1'b0;
            we1       <= '0;
            waddr1    <= '0;
            wdata1    <= '0;
            we2       <= '0;
            waddr2    <= '0;
            wdata2    <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                head_half <= 1'b0;
            end else if (half_set) begin
                head_half <= 1'b1;
            end
            unique case ({store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            we1    <= nxt_we1;
            waddr1 <= nxt_waddr1;
            wdata1 <= nxt_wdata1;
            we2    <= nxt_we2;
            waddr2 <= nxt_waddr2;
            wdata2 <= nxt_wdata2;
        end
    end

    // Pending mask: every active slot still held in the queue, minus the
    // already-issued slot 1 of a split head.
    always_comb begin
        logic [AW-1:0] off;
        pending = '0;
        off     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr;
            if (CW'(off) < count) begin
                if ((|fifo_q[AW'(i)].we1) && !(head_half && (off == '0))) begin
                    pending[fifo_q[AW'(i)].waddr1] = 1'b1;
                end
                if (|fifo_q[AW'(i)].we2) begin
                    pending[fifo_q[AW'(i)].waddr2] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_regwriter.sv
// tb_wb_regwriter: scoreboard bench for wb_regwriter. A slot-level reference
// model predicts each cycle's port outputs into a queue; a negedge monitor
// pops and compares them, together with count, pending and ex_ready.
module tb_wb_regwriter;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   ex_valid;
    logic                   ex_ready;
    logic [1:0]             ex_we1;
    logic [2:0]             ex_waddr1;
    logic [15:0]            ex_wdata1;
    logic [1:0]             ex_we2;
    logic [2:0]             ex_waddr2;
    logic [15:0]            ex_wdata2;
    logic                   mem_valid;
    logic [1:0]             mem_we;
    logic [2:0]             mem_waddr;
    logic [15:0]            mem_wdata;
    logic [1:0]             we1;
    logic [2:0]             waddr1;
    logic [15:0]            wdata1;
    logic [1:0]             we2;
    logic [2:0]             waddr2;
    logic [15:0]            wdata2;
    logic [7:0]             pending;
    logic [$clog2(DEPTH):0] count;

    wb_regwriter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_we1    (ex_we1),
        .ex_waddr1 (ex_waddr1),
        .ex_wdata1 (ex_wdata1),
        .ex_we2    (ex_we2),
        .ex_waddr2 (ex_waddr2),
        .ex_wdata2 (ex_wdata2),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .we2       (we2),
        .waddr2    (waddr2),
        .wdata2    (wdata2),
        .pending   (pending),
        .count     (count)
    );

    always #5 clk = ~clk;

    // One register write still owed by the queue; last marks the end of an
    // EX entry, and a we=0 record stands for an entry with no active slot.
    typedef struct {
        logic [1:0]  we;
        logic [2:0]  addr;
        logic [15:0] data;
        bit          last;
    } slot_t;

    typedef struct {
        logic [1:0]  we1;
        logic [2:0]  a1;
        logic [15:0] d1;
        logic [1:0]  we2;
        logic [2:0]  a2;
        logic [15:0] d2;
    } port_t;

    slot_t mq[$];
    slot_t iss[$];
    port_t sb[$];
    port_t hold;
    bit    started = 0;
    int    checks  = 0;
    int    errors  = 0;

    function automatic int model_count();
        int n = 0;
        foreach (mq[i]) if (mq[i].last) n++;
        return n;
    endfunction

    function automatic logic [7:0] model_pending();
        logic [7:0] p = '0;
        foreach (mq[i]) if (mq[i].we != 2'b00) p[mq[i].addr] = 1'b1;
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two credits per cycle, a load takes one on port 2,
    // and the oldest entry's remaining writes take what is left in order.
    always @(posedge clk) begin : ref_model
        port_t e;
        slot_t s;
        int    budget;
        bit    accept;
        bit    was_empty;
        bit    bypassed;
        int    n_in;
        if (reset) begin
            mq.delete();
            e    = '{2'b00, 3'd0, 16'h0, 2'b00, 3'd0, 16'h0};
            hold = e;
        end else begin
            accept    = ex_valid && (model_count() < DEPTH);
            was_empty = (mq.size() == 0);
            budget    = mem_valid ? 1 : 2;
            bypassed  = 0;
            iss.delete();
            while (mq.size() > 0) begin
                if (mq[0].we == 2'b00) begin
                    void'(mq.pop_front());
                    break;
                end
                if (budget == 0) break;
                s = mq.pop_front();
                iss.push_back(s);
                budget--;
                if (s.last) break;
            end
`ifdef WB_BYPASS_EN
            n_in = int'(ex_we1 != 2'b00) + int'(ex_we2 != 2'b00);
            if (accept && was_empty && n_in <= budget) begin
                bypassed = 1;
                if (ex_we1 != 2'b00) iss.push_back('{ex_we1, ex_waddr1, ex_wdata1, 1'b0});
                if (ex_we2 != 2'b00) iss.push_back('{ex_we2, ex_waddr2, ex_wdata2, 1'b1});
            end
`else
            n_in = 0;
            if (was_empty && n_in < 0) bypassed = 1;
`endif
            if (accept && !bypassed) begin
                if (ex_we1 != 2'b00 && ex_we2 != 2'b00) begin
                    mq.push_back('{ex_we1, ex_waddr1, ex_wdata1, 1'b0});
                    mq.push_back('{ex_we2, ex_waddr2, ex_wdata2, 1'b1});
                end else if (ex_we1 != 2'b00) begin
                    mq.push_back('{ex_we1, ex_waddr1, ex_wdata1, 1'b1});
                end else if (ex_we2 != 2'b00) begin
                    mq.push_back('{ex_we2, ex_waddr2, ex_wdata2, 1'b1});
                end else begin
                    mq.push_back('{2'b00, 3'd0, 16'h0, 1'b1});
                end
            end
            e     = hold;
            e.we1 = 2'b00;
            e.we2 = 2'b00;
            if (iss.size() >= 1) begin
                e.we1 = iss[0].we;
                e.a1  = iss[0].addr;
                e.d1  = iss[0].data;
            end
            if (mem_valid) begin
                e.we2 = mem_we;
                e.a2  = mem_waddr;
                e.d2  = mem_wdata;
            end else if (iss.size() == 2) begin
                e.we2 = iss[1].we;
                e.a2  = iss[1].addr;
                e.d2  = iss[1].data;
            end
            hold = e;
        end
        sb.push_back(e);
        started = 1;
    end

    // Monitor: the DUT presents a port record every cycle; pop and compare.
    always @(negedge clk) begin : monitor
        port_t e;
        if (started) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got no expected record at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("we1",    32'(we1),    32'(e.we1));
                chk("waddr1", 32'(waddr1), 32'(e.a1));
                chk("wdata1", 32'(wdata1), 32'(e.d1));
                chk("we2",    32'(we2),    32'(e.we2));
                chk("waddr2", 32'(waddr2), 32'(e.a2));
                chk("wdata2", 32'(wdata2), 32'(e.d2));
            end
            chk("count",    32'(count),    32'(model_count()));
            chk("pending",  32'(pending),  32'(model_pending()));
            chk("ex_ready", 32'(ex_ready), 32'(!reset && (model_count() < DEPTH)));
        end
    end

    task automatic drive(input bit ev,
                         input logic [1:0] w1, input logic [2:0] a1, input logic [15:0] d1,
                         input logic [1:0] w2, input logic [2:0] a2, input logic [15:0] d2,
                         input bit mv, input logic [1:0] mw, input logic [2:0] ma,
                         input logic [15:0] md);
        ex_valid  = ev;
        ex_we1    = w1;
        ex_waddr1 = a1;
        ex_wdata1 = d1;
        ex_we2    = w2;
        ex_waddr2 = a2;
        ex_wdata2 = d2;
        mem_valid = mv;
        mem_we    = mw;
        mem_waddr = ma;
        mem_wdata = md;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 2'b00, 3'd0, 16'h0, 2'b00, 3'd0, 16'h0, 0, 2'b00, 3'd0, 16'h0);
    endtask

    initial begin
        reset = 1'b1;
        ex_valid = 0; ex_we1 = '0; ex_waddr1 = '0; ex_wdata1 = '0;
        ex_we2 = '0; ex_waddr2 = '0; ex_wdata2 = '0;
        mem_valid = 0; mem_we = '0; mem_waddr = '0; mem_wdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // single entry, slot 1 only
        drive(1, 2'b11, 3'd3, 16'h1234, 2'b00, 3'd0, 16'h0, 0, 2'b00, 3'd0, 16'h0);
        idle(4);

        // two-slot head meets a load return on its first scheduling cycle
        drive(1, 2'b11, 3'd0, 16'h1111, 2'b11, 3'd1, 16'h2222, 0, 2'b00, 3'd0, 16'h0);
        drive(0, 2'b00, 3'd0, 16'h0, 2'b00, 3'd0, 16'h0, 1, 2'b11, 3'd2, 16'h3333);
        idle(4);

        // backpressure: loads every cycle, every entry has two active slots
        for (int i = 0; i < 14; i++)
            drive(1, 2'b11, 3'(i), 16'(16'hA000 + i), 2'b11, 3'(i + 1), 16'(16'hB000 + i),
                  1, 2'b01, 3'd7, 16'(16'hC000 + i));
        idle(10);

        // entry with no active slots
        drive(1, 2'b00, 3'd5, 16'h5555, 2'b00, 3'd6, 16'h6666, 0, 2'b00, 3'd0, 16'h0);
        idle(3);

        // byte writes to AX from EX then from a load
        drive(1, 2'b01, 3'd0, 16'h00AB, 2'b00, 3'd0, 16'h0, 0, 2'b00, 3'd0, 16'h0);
        drive(0, 2'b00, 3'd0, 16'h0, 2'b00, 3'd0, 16'h0, 1, 2'b10, 3'd0, 16'hCD00);
        idle(3);

        // split head plus queued entries, then a one-cycle reset
        for (int i = 0; i < 4; i++)
            drive(1, 2'b11, 3'd4, 16'(16'hD000 + i), 2'b10, 3'd5, 16'(16'hE000 + i),
                  1, 2'b11, 3'd6, 16'hF00F);
        drive(0, 2'b00, 3'd0, 16'h0, 2'b00, 3'd0, 16'h0, 1, 2'b11, 3'd6, 16'hF00F);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(4);

        // randomized traffic with occasional resets and varying load pressure
        for (int i = 0; i < 3000; i++) begin
            int mprob;
            mprob = (i < 1500) ? 3 : 8;
            reset = ($urandom_range(0, 249) == 0);
            drive($urandom_range(0, 2) != 0,
                  2'($urandom_range(0, 3)), 3'($urandom), 16'($urandom),
                  2'($urandom_range(0, 3)), 3'($urandom), 16'($urandom),
                  $urandom_range(0, 9) < mprob,
                  2'($urandom_range(1, 3)), 3'($urandom), 16'($urandom));
        end
        reset = 1'b0;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
